// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART slave: TX FIFO + serializer, 2-flop RX synchronizer +
// deserializer + RX FIFO, and STATUS/CTRL registers decoded from address[3:2].
module uart_mmio_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    input  logic                  rx,
    output logic                  tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    // Register decode
    logic [1:0] reg_sel;
    assign reg_sel = address[3:2];

    // Only the low byte of wd and address[3:2] carry meaning
    logic unused_inputs;
    assign unused_inputs = ^{address[31:4], address[1:0], wd[DATA_WIDTH-1:8]};

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [CW-1:0] tx_count_q;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_count_q == DEPTH_C);
    assign tx_empty = (tx_count_q == '0);
    assign tx_push  = we && (reg_sel == 2'd0) && !tx_full;

    // TX storage write (no reset: contents are meaningless once pointers reset)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= wd[7:0];
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PW'(1);
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count_q <= tx_count_q + CW'(1);
                2'b01:   tx_count_q <= tx_count_q - CW'(1);
                default: tx_count_q <= tx_count_q;
            endcase
        end
    end

    // ---------------- TX serializer ----------------
    tx_state_t     tx_state_q, tx_state_d;
    logic [BW-1:0] tx_baud_q, tx_baud_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;

    // TX state register; tx line is registered so it is glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // TX next state: frame timing and FIFO pop; line level follows the next state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_mem[tx_rd_ptr_q];
                    tx_baud_d  = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_baud_d = tx_baud_q + BW'(1);
                end
            end
            TX_DATA: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_baud_d = tx_baud_q + BW'(1);
                end
            end
            TX_STOP: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_baud_d = tx_baud_q + BW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx = tx_q;

    // ---------------- RX synchronizer ----------------
    logic rx_sync1_q, rx_sync2_q, rx_s;

    // Two-flop synchronizer for the asynchronous rx pin, idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= rx;
            rx_sync2_q <= rx_sync1_q;
        end
    end
    assign rx_s = rx_sync2_q;

    // ---------------- RX deserializer ----------------
    rx_state_t     rx_state_q, rx_state_d;
    logic [BW-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_push_req, rx_ferr_set;

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: mid-bit sampling, glitch rejection, stop-bit validation
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_baud_d   = rx_baud_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_req = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_baud_q == BAUD_HALF) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + BW'(1);
                end
            end
            RX_DATA: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_baud_d = rx_baud_q + BW'(1);
                end
            end
            RX_STOP: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d = '0;
                    if (rx_s) begin
                        rx_push_req = 1'b1;
                        rx_state_d  = RX_IDLE;
                    end else begin
                        rx_ferr_set = 1'b1;
                        rx_state_d  = RX_WAIT;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BW'(1);
                end
            end
            RX_WAIT: begin
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [CW-1:0] rx_count_q;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    assign rx_full  = (rx_count_q == DEPTH_C);
    assign rx_empty = (rx_count_q == '0);
    assign rx_pop   = re && (reg_sel == 2'd1) && !rx_empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO is still taken
    assign rx_push  = rx_push_req && (!rx_full || rx_pop);

    // RX storage write
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_shift_q;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PW'(1);
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count_q <= rx_count_q + CW'(1);
                2'b01:   rx_count_q <= rx_count_q - CW'(1);
                default: rx_count_q <= rx_count_q;
            endcase
        end
    end

    // ---------------- Sticky flags ----------------
    logic overrun_q, overrun_d, frame_err_q, frame_err_d, ctrl_clr;

    assign ctrl_clr = we && (reg_sel == 2'd3) && wd[0];

    // Sticky flag next state: a new event on the clearing edge wins
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (ctrl_clr) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_push_req && rx_full && !rx_pop) overrun_d = 1'b1;
        if (rx_ferr_set) frame_err_d = 1'b1;
    end

    // Sticky flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------- Read mux ----------------
    logic tx_busy;
    assign tx_busy = (tx_state_q != TX_IDLE);

    // Combinational read data; RXDATA shows the current head (pre-pop value)
    always_comb begin
        rd = '0;
        case (reg_sel)
            2'd1: if (!rx_empty) rd[7:0] = rx_mem[rx_rd_ptr_q];
            2'd2: rd[6:0] = {frame_err_q, tx_busy, overrun_q, rx_full,
                             rx_empty, tx_empty, tx_full};
            default: rd = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Scoreboard bench for uart_mmio_fifo: queue-based reference model, a read
// monitor for bus reads and a line monitor that decodes tx frames.
module tb_uart_mmio_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] wd = '0;
    logic [31:0]   address = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [DW-1:0] rd;
    logic          rx = 1'b1;
    logic          tx;

    uart_mmio_fifo #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wd     (wd),
        .address(address),
        .we     (we),
        .re     (re),
        .rd     (rd),
        .rx     (rx),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;
    rd_exp_t rd_q[$];

    // Reference model state
    byte unsigned tx_fifo[$];   // bytes accepted but not yet started on the line
    byte unsigned rx_fifo[$];   // bytes received and not yet popped
    bit ovr_m  = 1'b0;
    bit ferr_m = 1'b0;
    bit in_frame = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("pass %s: 0x%08h", name, act);
        end
    endfunction

    function automatic logic [31:0] status_exp(input bit busy);
        return {25'b0, ferr_m, busy, ovr_m,
                rx_fifo.size() == DEPTH, rx_fifo.size() == 0,
                tx_fifo.size() == 0, tx_fifo.size() == DEPTH};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address = a;
        wd      = d;
        we      = 1'b1;
        if (a[3:2] == 2'd0 && tx_fifo.size() < DEPTH) tx_fifo.push_back(d[7:0]);
        if (a[3:2] == 2'd3 && d[0]) begin
            ovr_m  = 1'b0;
            ferr_m = 1'b0;
        end
        $display("write addr=0x%08h data=0x%08h", a, d);
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp,
                            input string name);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        rd_q.push_back(e);
        address = a;
        re      = 1'b1;
        @(posedge clk);
        #1;
        re = 1'b0;
    endtask

    task automatic read_status(input bit busy, input string name);
        bus_read(32'h8, status_exp(busy), name);
    endtask

    task automatic read_rx(input string name);
        logic [31:0] e;
        e = '0;
        if (rx_fifo.size() > 0) e = {24'b0, rx_fifo.pop_front()};
        bus_read(32'h4, e, name);
    endtask

    task automatic send_rx(input byte unsigned b, input bit stop);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        if (stop) begin
            if (rx_fifo.size() < DEPTH) rx_fifo.push_back(b);
            else                        ovr_m = 1'b1;
        end else begin
            ferr_m = 1'b1;
        end
        $display("rx frame 0x%02h stop=%0d", b, stop);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_drain(input string name);
        bit expired;
        expired = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (tx_fifo.size() == 0 && !in_frame) begin
                expired = 1'b0;
                break;
            end
            @(posedge clk);
        end
        repeat (CPB) @(posedge clk);
        #1;
        check(name, {31'b0, expired}, 32'h0);
    endtask

    // Bus read monitor: compares rd against the scoreboard on every read cycle
    always @(negedge clk) begin
        rd_exp_t e;
        if (re) begin
            if (rd_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_read: got 0x%08h expected none", rd);
            end else begin
                e = rd_q.pop_front();
                check(e.name, rd, e.val);
            end
        end
    end

    // Line monitor: decodes each tx frame, checks timing and byte order
    initial begin
        byte unsigned got, exp;
        bit have_exp, aborted, back_to_back;
        int unsigned t0, last_start;
        back_to_back = 1'b0;
        last_start   = 0;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                t0 = cyc;
                if (back_to_back) check("tx_start_gap", t0 - last_start, 10 * CPB + 1);
                last_start = t0;
                have_exp = (tx_fifo.size() > 0);
                exp = 8'h00;
                if (have_exp) exp = tx_fifo.pop_front();
                else begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_tx_frame: got start bit expected idle");
                end
                in_frame = 1'b1;
                aborted  = 1'b0;
                got      = 8'h00;
                for (int k = 1; k <= 9 * CPB + CPB / 2; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k == CPB / 2) check("tx_start_bit", {31'b0, tx}, 32'h0);
                    else if (k == 9 * CPB + CPB / 2) check("tx_stop_bit", {31'b0, tx}, 32'h1);
                    else if ((k - CPB / 2) % CPB == 0) got[(k - CPB / 2) / CPB - 1] = tx;
                end
                if (!aborted && have_exp) check("tx_frame_byte", {24'b0, got}, {24'b0, exp});
                back_to_back = !aborted && (tx_fifo.size() > 0);
                in_frame = 1'b0;
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte unsigned b;
        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tx_in_reset", {31'b0, tx}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_status(1'b0, "status_after_reset");
        bus_read(32'h4, 32'h0, "rxdata_empty");
        bus_read(32'h0, 32'h0, "txdata_reads_zero");
        bus_read(32'hC, 32'h0, "ctrl_reads_zero");
        check("tx_idle", {31'b0, tx}, 32'h1);

        // TX: one byte in flight, then fill the FIFO behind it
        bus_write(32'h0, 32'h1A5);
        repeat (3) @(posedge clk);
        #1;
        read_status(1'b1, "status_tx_busy");
        for (int i = 0; i < 5; i++) begin
            bus_write(32'h0, 32'h11 + i);
            read_status(1'b1, $sformatf("status_after_txwr%0d", i));
        end
        wait_tx_drain("tx_drain_1");
        read_status(1'b0, "status_tx_done");

        // TX: random burst
        for (int i = 0; i < 3; i++) bus_write(32'h0, $urandom);
        wait_tx_drain("tx_drain_2");

        // RX: single byte
        send_rx(8'h3C, 1'b1);
        read_status(1'b0, "status_rx_one");
        read_rx("rxdata_3c");
        read_status(1'b0, "status_rx_popped");

        // RX: overrun
        for (int i = 0; i < 5; i++) send_rx(8'($urandom), 1'b1);
        read_status(1'b0, "status_rx_overrun");
        for (int i = 0; i < 4; i++) read_rx($sformatf("rx_pop%0d", i));
        read_status(1'b0, "status_rx_drained");
        bus_write(32'hC, 32'h1);
        read_status(1'b0, "status_ovr_cleared");
        read_rx("rx_pop_empty");

        // RX: framing error
        send_rx(8'($urandom), 1'b0);
        read_status(1'b0, "status_frame_err");
        read_rx("rx_after_frame_err");
        bus_write(32'hC, 32'h1);
        read_status(1'b0, "status_ferr_cleared");

        // RX: short glitch
        rx = 1'b0;
        repeat (2) @(posedge clk);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        read_status(1'b0, "status_after_glitch");
        read_rx("rx_after_glitch");

        // RX: random frames with random pops
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            if ($urandom_range(0, 1) == 1) read_rx($sformatf("rx_mix_pop%0d", i));
        end
        read_status(1'b0, "status_mix");
        while (rx_fifo.size() > 0) read_rx("rx_mix_drain");
        bus_write(32'hC, 32'h1);
        read_status(1'b0, "status_mix_cleared");

        // Reset in the middle of a tx frame
        bus_write(32'h0, 32'hF0);
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("tx_async_reset", {31'b0, tx}, 32'h1);
        tx_fifo.delete();
        rx_fifo.delete();
        ovr_m  = 1'b0;
        ferr_m = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        read_status(1'b0, "status_after_midframe_reset");
        repeat (100) @(posedge clk);
        #1;
        check("tx_idle_after_reset", {31'b0, tx}, 32'h1);

        repeat (5) @(posedge clk);
        check("read_queue_empty", rd_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
